// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - upstream, data-memory and writeback signal bundle for mem_access_stage
interface mem_access_stage_if;
  // upstream (execute) side
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [63:0] in_alu_output;
  logic [63:0] in_store_data;
  logic        in_memread;
  logic        in_memwrite;
  logic [4:0]  in_rd;
  logic        in_regwrite;

  // data-memory bus
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  // writeback side
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic        out_misaligned;
  logic        out_bus_err;

  // the stage itself
  modport master (
    input  in_valid, in_instruction, in_alu_output, in_store_data,
           in_memread, in_memwrite, in_rd, in_regwrite,
    output in_ready,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output out_valid, out_wb_data, out_rd, out_regwrite, out_misaligned, out_bus_err,
    input  out_ready
  );

  // execute stage, memory and writeback around the stage
  modport slave (
    output in_valid, in_instruction, in_alu_output, in_store_data,
           in_memread, in_memwrite, in_rd, in_regwrite,
    input  in_ready,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  out_valid, out_wb_data, out_rd, out_regwrite, out_misaligned, out_bus_err,
    output out_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage with aligned load/store bus transactions
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst,
  mem_access_stage_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;

  // op context kept across the bus transaction
  logic        op_store;
  logic        op_unsigned;
  logic [1:0]  op_size;
  logic [2:0]  op_off;
  logic        op_regwrite;

  // request registers, stable for the whole REQ phase
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;

  // writeback registers, stable for the whole DONE phase
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        wb_misaligned;
  logic        wb_bus_err;

  logic        in_ready_c;
  logic        accept;
  logic [2:0]  in_f3;
  logic [2:0]  in_off;
  logic        in_is_mem;
  logic        in_is_store;
  logic        in_misaligned;
  logic [7:0]  in_size_mask;
  logic [63:0] in_wdata;
  logic [7:0]  in_wmask;
  logic [63:0] ld_shift;
  logic [63:0] ld_ext;
  logic [7:0]  wait_cnt_next;
  logic        unused_bits;

  assign in_ready_c  = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
  assign accept      = bus.in_valid && in_ready_c;
  assign in_f3       = bus.in_instruction[14:12];
  assign in_off      = bus.in_alu_output[2:0];
  assign in_is_mem   = bus.in_memread || bus.in_memwrite;
  // a load wins when both memread and memwrite are set
  assign in_is_store = bus.in_memwrite && !bus.in_memread;
  assign in_wdata    = bus.in_store_data << {in_off, 3'b000};
  assign in_wmask    = in_size_mask << in_off;
  assign ld_shift    = bus.mem_resp_rdata >> {op_off, 3'b000};
  assign wait_cnt_next = wait_cnt + 8'd1;
  assign unused_bits = ^{bus.in_instruction[31:15], bus.in_instruction[11:0]};

  // access size decode: byte-lane mask and natural-alignment test
  always_comb begin
    in_size_mask  = 8'h01;
    in_misaligned = 1'b0;
    case (in_f3[1:0])
      2'b00: in_size_mask = 8'h01;
      2'b01: begin
        in_size_mask  = 8'h03;
        in_misaligned = in_off[0];
      end
      2'b10: begin
        in_size_mask  = 8'h0F;
        in_misaligned = |in_off[1:0];
      end
      default: begin
        in_size_mask  = 8'hFF;
        in_misaligned = |in_off;
      end
    endcase
  end

  // pick the addressed bytes out of the doubleword and sign/zero extend
  always_comb begin
    ld_ext = ld_shift;
    case (op_size)
      2'b00: ld_ext = op_unsigned ? {56'b0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'b01: ld_ext = op_unsigned ? {48'b0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'b10: ld_ext = op_unsigned ? {32'b0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // stage FSM: accept -> (REQ -> WAIT ->) DONE, with back-to-back accept out of DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= 8'd0;
      op_store      <= 1'b0;
      op_unsigned   <= 1'b0;
      op_size       <= 2'b00;
      op_off        <= 3'b000;
      op_regwrite   <= 1'b0;
      req_addr      <= 64'd0;
      req_wen       <= 1'b0;
      req_wdata     <= 64'd0;
      req_wmask     <= 8'd0;
      wb_data       <= 64'd0;
      wb_rd         <= 5'd0;
      wb_regwrite   <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else if (accept) begin
      op_store      <= in_is_store;
      op_unsigned   <= in_f3[2];
      op_size       <= in_f3[1:0];
      op_off        <= in_off;
      op_regwrite   <= bus.in_regwrite;
      wb_rd         <= bus.in_rd;
      wb_data       <= bus.in_alu_output;
      wb_regwrite   <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_bus_err    <= 1'b0;
      if (!in_is_mem) begin
        state       <= S_DONE;
        wb_regwrite <= bus.in_regwrite;
      end else if (in_misaligned) begin
        // faulting access never reaches the bus; report the address instead
        state         <= S_DONE;
        wb_misaligned <= 1'b1;
      end else begin
        state     <= S_REQ;
        req_addr  <= {bus.in_alu_output[63:3], 3'b000};
        req_wen   <= in_is_store;
        req_wdata <= in_is_store ? in_wdata : 64'd0;
        req_wmask <= in_is_store ? in_wmask : 8'd0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (bus.mem_req_ready) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd0;
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            state       <= S_DONE;
            wb_data     <= op_store ? 64'd0 : ld_ext;
            wb_regwrite <= op_store ? 1'b0 : op_regwrite;
          end else if (wait_cnt_next == TIMEOUT_LIM) begin
            // no response: abort with a bus error and suppress the register write
            state       <= S_DONE;
            wb_data     <= 64'd0;
            wb_regwrite <= 1'b0;
            wb_bus_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt_next;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.mem_req_valid  = (state == S_REQ);
  assign bus.mem_req_addr   = req_addr;
  assign bus.mem_req_wen    = req_wen;
  assign bus.mem_req_wdata  = req_wdata;
  assign bus.mem_req_wmask  = req_wmask;
  assign bus.out_valid      = (state == S_DONE);
  assign bus.out_wb_data    = wb_data;
  assign bus.out_rd         = wb_rd;
  assign bus.out_regwrite   = wb_regwrite;
  assign bus.out_misaligned = wb_misaligned;
  assign bus.out_bus_err    = wb_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard testbench for mem_access_stage
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0] wb;
    logic        chk_wb;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        err;
  } out_exp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_exp_t;

  out_exp_t exp_q[$];
  req_exp_t req_q[$];
  int       pop_cyc[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory model controls
  int          ready_delay = 0;
  int          resp_delay  = 0;
  bit          resp_enable = 1'b1;
  bit          manual      = 1'b0;
  logic [63:0] resp_rdata  = 64'd0;
  bit          hs_pending  = 1'b0;
  bit          waiting     = 1'b0;
  int          wcnt        = 0;
  int          rdy_cnt     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_out(input logic [63:0] wb, input logic cw, input logic [4:0] rd,
                          input logic rw, input logic mis, input logic err);
    out_exp_t e;
    e.wb = wb; e.chk_wb = cw; e.rd = rd; e.rw = rw; e.mis = mis; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic push_req(input logic [63:0] addr, input logic wen,
                          input logic [63:0] wdata, input logic [7:0] wmask);
    req_exp_t r;
    r.addr = addr; r.wen = wen; r.wdata = wdata; r.wmask = wmask;
    req_q.push_back(r);
  endtask

  // memory responder: drives ready/response at posedge+1
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (hs_pending) begin
        waiting = 1'b1;
        wcnt    = 0;
      end
      hs_pending = 1'b0;
      if (manual) begin
        waiting = 1'b0;
      end else begin
        bus.mem_resp_valid = 1'b0;
        if (waiting) begin
          if (resp_enable && wcnt == resp_delay) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = resp_rdata;
            waiting = 1'b0;
          end
          wcnt++;
        end
      end
      if (bus.mem_req_valid) begin
        if (rdy_cnt < ready_delay) begin
          bus.mem_req_ready = 1'b0;
          rdy_cnt++;
        end else begin
          bus.mem_req_ready = 1'b1;
          rdy_cnt = 0;
        end
      end else begin
        bus.mem_req_ready = 1'b0;
        rdy_cnt = 0;
      end
      hs_pending = bus.mem_req_valid && bus.mem_req_ready;
    end
  end

  // monitor: compare bus requests and writeback outputs against the scoreboard
  always @(negedge clk) begin : mon
    req_exp_t r;
    out_exp_t e;
    if (!rst && bus.mem_req_valid && bus.mem_req_ready) begin
      if (req_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_req addr=%h required=none", bus.mem_req_addr);
      end else begin
        r = req_q.pop_front();
        chk("req_addr", bus.mem_req_addr, r.addr);
        chk("req_wen", 64'(bus.mem_req_wen), 64'(r.wen));
        chk("req_wmask", 64'(bus.mem_req_wmask), 64'(r.wmask));
        if (r.wen) chk("req_wdata", bus.mem_req_wdata, r.wdata);
      end
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out wb=%h required=none", bus.out_wb_data);
      end else begin
        e = exp_q.pop_front();
        pop_cyc.push_back(cyc);
        if (e.chk_wb) chk("out_wb_data", bus.out_wb_data, e.wb);
        chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
        chk("out_regwrite", 64'(bus.out_regwrite), 64'(e.rw));
        chk("out_misaligned", 64'(bus.out_misaligned), 64'(e.mis));
        chk("out_bus_err", 64'(bus.out_bus_err), 64'(e.err));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] sd,
                       input logic mr, input logic mw, input logic [4:0] rd, input logic rw);
    int n;
    bus.in_instruction = {17'h0, f3, 12'h003};
    bus.in_alu_output  = alu;
    bus.in_store_data  = sd;
    bus.in_memread     = mr;
    bus.in_memwrite    = mw;
    bus.in_rd          = rd;
    bus.in_regwrite    = rw;
    bus.in_valid       = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] snap_wb;
    logic [4:0]  snap_misc;
    int          wait_cycles;
    int          n;

    bus.in_valid = 1'b0;
    bus.in_instruction = 32'd0;
    bus.in_alu_output = 64'd0;
    bus.in_store_data = 64'd0;
    bus.in_memread = 1'b0;
    bus.in_memwrite = 1'b0;
    bus.in_rd = 5'd0;
    bus.in_regwrite = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_wb_data", bus.out_wb_data, 64'd0);
    chk("rst_regwrite", 64'(bus.out_regwrite), 64'd0);
    chk("rst_flags", 64'({bus.out_misaligned, bus.out_bus_err}), 64'd0);
    chk("rst_req_addr", bus.mem_req_addr, 64'd0);
    chk("rst_req_wmask", 64'(bus.mem_req_wmask), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // non-memory back-to-back stream
    pop_cyc.delete();
    push_out(64'h11, 1, 5'd5, 1, 0, 0);
    push_out(64'h22, 1, 5'd5, 1, 0, 0);
    push_out(64'h33, 1, 5'd5, 1, 0, 0);
    issue(3'b000, 64'h11, 64'd0, 0, 0, 5'd5, 1);
    issue(3'b000, 64'h22, 64'd0, 0, 0, 5'd5, 1);
    issue(3'b000, 64'h33, 64'd0, 0, 0, 5'd5, 1);
    wait_drain();
    chk("stream_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() >= 3) begin
      chk("stream_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk("stream_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
    end

    // loads: size, offset and extension
    resp_rdata = 64'h0000_0000_8000_0000;
    push_req(64'h8000_0000, 0, 64'd0, 8'h00);
    push_out(64'hFFFF_FFFF_FFFF_FF80, 1, 5'd10, 1, 0, 0);
    issue(3'b000, 64'h8000_0003, 64'd0, 1, 0, 5'd10, 1);
    wait_drain();

    push_req(64'h8000_0000, 0, 64'd0, 8'h00);
    push_out(64'h0000_0000_0000_0080, 1, 5'd11, 1, 0, 0);
    issue(3'b100, 64'h8000_0003, 64'd0, 1, 0, 5'd11, 1);
    wait_drain();

    resp_rdata = 64'h0000_0000_8001_0000;
    push_req(64'h8000_0000, 0, 64'd0, 8'h00);
    push_out(64'hFFFF_FFFF_FFFF_8001, 1, 5'd12, 1, 0, 0);
    issue(3'b001, 64'h8000_0002, 64'd0, 1, 0, 5'd12, 1);
    wait_drain();

    resp_rdata = 64'hDEAD_BEEF_0000_0000;
    push_req(64'h8000_0000, 0, 64'd0, 8'h00);
    push_out(64'h0000_0000_DEAD_BEEF, 1, 5'd13, 1, 0, 0);
    issue(3'b110, 64'h8000_0004, 64'd0, 1, 0, 5'd13, 1);
    wait_drain();

    push_req(64'h8000_0000, 0, 64'd0, 8'h00);
    push_out(64'hFFFF_FFFF_DEAD_BEEF, 1, 5'd14, 1, 0, 0);
    issue(3'b010, 64'h8000_0004, 64'd0, 1, 0, 5'd14, 1);
    wait_drain();

    resp_rdata = 64'h0123_4567_89AB_CDEF;
    push_req(64'h8000_0008, 0, 64'd0, 8'h00);
    push_out(64'h0123_4567_89AB_CDEF, 1, 5'd15, 1, 0, 0);
    issue(3'b011, 64'h8000_0008, 64'd0, 1, 0, 5'd15, 1);
    wait_drain();

    // memread and memwrite both set: treated as a load
    resp_rdata = 64'h0000_0000_0000_0055;
    push_req(64'h8000_0010, 0, 64'd0, 8'h00);
    push_out(64'h55, 1, 5'd16, 1, 0, 0);
    issue(3'b011, 64'h8000_0010, 64'hFFFF, 1, 1, 5'd16, 1);
    wait_drain();

    // halfword store with request held off for 2 cycles
    ready_delay = 2;
    push_req(64'h8000_0000, 1, 64'h1234_0000_0000_0000, 8'hC0);
    push_out(64'd0, 1, 5'd17, 0, 0, 0);
    issue(3'b001, 64'h8000_0006, 64'h1234, 0, 1, 5'd17, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("stall_req_ready", 64'(bus.mem_req_ready), 64'd0);
      chk("stall_addr", bus.mem_req_addr, 64'h8000_0000);
      chk("stall_wdata", bus.mem_req_wdata, 64'h1234_0000_0000_0000);
      chk("stall_wmask", 64'(bus.mem_req_wmask), 64'hC0);
    end
    wait_drain();
    ready_delay = 0;

    push_req(64'h8000_0000, 1, 64'h0000_AB00_0000_0000, 8'h20);
    push_out(64'd0, 1, 5'd18, 0, 0, 0);
    issue(3'b000, 64'h8000_0005, 64'hAB, 0, 1, 5'd18, 1);
    wait_drain();

    push_req(64'h8000_0000, 1, 64'hCAFE_BABE_0000_0000, 8'hF0);
    push_out(64'd0, 1, 5'd19, 0, 0, 0);
    issue(3'b010, 64'h8000_0004, 64'hCAFE_BABE, 0, 1, 5'd19, 1);
    wait_drain();

    push_req(64'h8000_0018, 1, 64'h1122_3344_5566_7788, 8'hFF);
    push_out(64'd0, 1, 5'd20, 0, 0, 0);
    issue(3'b011, 64'h8000_0018, 64'h1122_3344_5566_7788, 0, 1, 5'd20, 1);
    wait_drain();

    // misaligned accesses: no bus request, address reported
    push_out(64'h8000_0002, 1, 5'd3, 0, 1, 0);
    issue(3'b010, 64'h8000_0002, 64'd0, 1, 0, 5'd3, 1);
    @(negedge clk);
    chk("mis_no_req", 64'(bus.mem_req_valid), 64'd0);
    wait_drain();

    push_out(64'h8000_0001, 1, 5'd4, 0, 1, 0);
    issue(3'b001, 64'h8000_0001, 64'd0, 1, 0, 5'd4, 1);
    wait_drain();

    push_out(64'h8000_0004, 1, 5'd6, 0, 1, 0);
    issue(3'b011, 64'h8000_0004, 64'h77, 0, 1, 5'd6, 1);
    wait_drain();

    // response timeout with output stall
    resp_enable = 1'b0;
    bus.out_ready = 1'b0;
    push_req(64'h8000_0020, 0, 64'd0, 8'h00);
    push_out(64'd0, 0, 5'd7, 0, 0, 1);
    issue(3'b010, 64'h8000_0020, 64'd0, 1, 0, 5'd7, 1);
    wait_cycles = 0;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      if (!bus.mem_req_valid) wait_cycles++;
      @(negedge clk);
      n++;
    end
    chk("timeout_reached", 64'(bus.out_valid), 64'd1);
    chk("timeout_wait_cycles", 64'(wait_cycles), 64'd4);
    chk("timeout_bus_err", 64'(bus.out_bus_err), 64'd1);
    chk("timeout_regwrite", 64'(bus.out_regwrite), 64'd0);
    snap_wb   = bus.out_wb_data;
    snap_misc = {bus.out_regwrite, bus.out_misaligned, bus.out_bus_err, bus.out_valid, bus.in_ready};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_wb_data", bus.out_wb_data, snap_wb);
      chk("hold_flags", 64'({bus.out_regwrite, bus.out_misaligned, bus.out_bus_err,
                             bus.out_valid, bus.in_ready}), 64'(snap_misc));
      chk("hold_rd", 64'(bus.out_rd), 64'd7);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    resp_enable = 1'b1;
    wait_drain();

    // fault flags cleared by the next accepted op
    push_out(64'h44, 1, 5'd8, 1, 0, 0);
    issue(3'b000, 64'h44, 64'd0, 0, 0, 5'd8, 1);
    wait_drain();

    // reset asserted while waiting for a response
    manual = 1'b1;
    bus.mem_resp_valid = 1'b0;
    push_req(64'h8000_0028, 0, 64'd0, 8'h00);
    issue(3'b011, 64'h8000_0028, 64'd0, 1, 0, 5'd9, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 64'hBAD;
    @(posedge clk);
    #1;
    bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_resp_no_out", 64'(bus.out_valid), 64'd0);
    end
    manual = 1'b0;

    wait_drain();
    chk("req_q_empty", 64'(req_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the integer execute stage.
- Consumes the ALU result (effective address or final result), store data and instruction bits.
- For loads and stores: runs one transaction on a valid/ready data-memory bus, aligns and extends load data.
- Non-memory instructions pass the ALU result through unchanged. Output goes to writeback with a valid/ready handshake.

Parameters:
TIMEOUT_CYCLES, 255, WAIT cycles without mem_resp_valid before the op is aborted with out_bus_err; 8-bit counter, legal 1..255.

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept an op this cycle
in_instruction  input  32  instruction; [14:12] funct3 selects size/sign
in_alu_output  input  64  effective address (mem ops) or result (others)
in_store_data  input  64  rs2 value for stores
in_memread  input  1  op is a load
in_memwrite  input  1  op is a store
in_rd  input  5  destination register
in_regwrite  input  1  op writes rd
mem_req_valid  output  1  bus request valid
mem_req_ready  input  1  bus accepts request
mem_req_addr  output  64  in_alu_output with [2:0] cleared
mem_req_wen  output  1  1 = store
mem_req_wdata  output  64  store data lane-shifted
mem_req_wmask  output  8  byte enables (0 for loads)
mem_resp_valid  input  1  response/ack (loads and stores)
mem_resp_rdata  input  64  aligned doubleword read data
out_valid  output  1  result valid to writeback
out_ready  input  1  writeback accepts
out_wb_data  output  64  writeback value
out_rd  output  5  destination register
out_regwrite  output  1  write enable, forced 0 on any fault
out_misaligned  output  1  address misaligned for access size
out_bus_err  output  1  response timeout

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state=IDLE; every output 0 except in_ready=1; all registers 0. Reset mid-operation drops any outstanding transaction; a late mem_resp_valid arriving in IDLE is ignored.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready; all inputs captured on accept.
- If in_memread & in_memwrite are both set, the op is a load.
- Accept, non-memory op -> DONE next cycle: out_wb_data=in_alu_output, out_regwrite=in_regwrite. 1-cycle latency.
- Accept, memory op, aligned -> REQ. Misaligned -> DONE directly, no bus request, out_misaligned=1, out_regwrite=0, out_wb_data=address.
- Size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 double. Loads: funct3[2]=1 means zero-extend.
- Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
- Byte offset o=addr[2:0].
  - Store: wdata = store_data << (8*o); wmask = ({1,3,15,255}[size]) << o.
  - Load: x = rdata >> (8*o); keep low 8/16/32/64 bits; extend by sign or zero.
- REQ: mem_req_valid=1, with addr, wen, wdata and wmask held stable until mem_req_ready. Handshake -> WAIT; timeout counter cleared.
- WAIT: mem_req_valid=0.
  - mem_resp_valid -> DONE. Loads: out_wb_data = extended data, out_regwrite=in_regwrite. Stores: out_wb_data=0, out_regwrite=0.
  - Otherwise counter+1; when it reaches TIMEOUT_CYCLES -> DONE with out_bus_err=1, out_regwrite=0.
- Response timing: a response arrives ≥1 cycle after the request handshake. mem_resp_valid in IDLE, REQ or DONE is ignored.
- DONE: out_valid=1 and all out_* held stable until out_ready.
  - out_ready & in_valid: next op accepted in the same cycle (back-to-back).
  - out_ready only: -> IDLE, out_valid=0.
- Fault flags are valid only with out_valid and clear when the next op is accepted.
- Throughput: 1 op/cycle for non-memory ops. A memory op is at least 3 cycles (REQ, WAIT, DONE) with zero-wait memory.

Test Plan:
- Reset asserted mid-WAIT -> next cycle in_ready=1, out_valid=0, mem_req_valid=0; a subsequent mem_resp_valid causes no out_valid.
- Non-memory stream: 3 back-to-back ops, alu 0x11/0x22/0x33, rd=5, out_ready=1 -> out_valid on 3 consecutive cycles with wb_data 0x11, 0x22, 0x33.
- lb funct3=000, addr 0x80000003, rdata 0x0000_0000_8000_0000 -> byte 0x80 -> out_wb_data=0xFFFF_FFFF_FFFF_FF80. lbu at the same address -> 0x80. lwu addr 0x80000004, rdata 0xDEADBEEF_00000000 -> 0x00000000_DEADBEEF.
- sh addr 0x80000006, store_data 0x1234 -> mem_req_addr=0x80000000, wmask=0xC0, wdata=0x1234_0000_0000_0000, wen=1; mem_req_ready low for 2 cycles keeps the request stable.
- lw at 0x80000002 -> no mem_req_valid, out_misaligned=1, out_regwrite=0, out_wb_data=0x80000002.
- Load accepted but mem_resp_valid never asserted, TIMEOUT_CYCLES=4 -> out_bus_err=1 after 4 WAIT cycles; out_ready held low 3 cycles keeps all outputs stable.
